// File: rtl/hd44780_cmd_queue_pkg.sv
// ---------------------------------------------------------------------------
// hd44780_cmd_queue_pkg
//   Shared types and constants for the HD44780 command queue.
//   This file also provides the hd44780 build/sim timing defaults. Each one
//   can be overridden by a `define set earlier in the build:
//     H4_DELAY_53US   : post-byte settle ticks (53 us at 50 MHz)
//     H4_DELAY_1P52MS : post clear/home settle ticks (1.52 ms at 50 MHz)
//     H4_TIMER_BITS   : width of the settle-delay counter
//   Contents of the package:
//     h4_entry_t      : one queued byte {rs, data}
//     WBUSY_TIMEOUT   : cycles to wait for the sender's busy flag
//     is_long_cmd()   : true for clear/home commands that need the long delay
// ---------------------------------------------------------------------------
`ifndef H4_DELAY_53US
`define H4_DELAY_53US 2650
`endif
`ifndef H4_DELAY_1P52MS
`define H4_DELAY_1P52MS 76000
`endif
`ifndef H4_TIMER_BITS
`define H4_TIMER_BITS 17
`endif

package hd44780_cmd_queue_pkg;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } h4_entry_t;

    localparam int WBUSY_TIMEOUT = 4;

    // Clear display (0x01) and return home (0x02/0x03) are the only
    // commands with the multi-millisecond execution time.
    function automatic logic is_long_cmd(input h4_entry_t e);
        return !e.rs && ((e.data[7:1] == 7'b0000000) || (e.data[7:1] == 7'b0000001));
    endfunction

endpackage

// File: rtl/hd44780_cmd_fifo.sv
// ---------------------------------------------------------------------------
// hd44780_cmd_fifo
//   Circular FIFO of {rs, data} entries. DEPTH must be a power of 2. With
//   that, the pointers wrap modulo DEPTH through their natural overflow.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push        : write request. It is ignored while full.
//     push_entry  : entry to write
//     pop         : read request. It is ignored while empty.
//     head        : entry at the read pointer (combinational)
//     full, empty : occupancy flags
//     count       : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module hd44780_cmd_fifo
    import hd44780_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  h4_entry_t              push_entry,
    input  logic                   pop,
    output h4_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    h4_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // The storage array has no reset. Only the pointers and the count
    // define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // A simultaneous push and pop leaves the count unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hd44780_cmd_queue.sv
// ---------------------------------------------------------------------------
// hd44780_cmd_queue
//   Buffers HD44780 bytes and sends them one at a time to a byte sender.
//   After each byte the queue waits out the LCD execution time. Clear and
//   home commands get the long delay. Every other byte gets the short delay.
//   Handshake with the byte sender: o_stb is a one-cycle pulse. o_rs and
//   o_data are valid from that pulse until the sender has raised and then
//   dropped i_bs_busy. If busy never rises within WBUSY_TIMEOUT cycles, the
//   byte counts as sent and the sequencer does not stall.
//   Ports:
//     CLK_I, RST_I         : clock, asynchronous active-low reset
//     i_wr, i_rs, i_data   : push request and the byte to queue
//     o_full, o_empty      : FIFO flags
//     o_count              : FIFO occupancy
//     o_stb, o_rs, o_data  : byte to the sender (registered)
//     i_bs_busy            : byte sender busy
//     o_busy               : queue non-empty or sequencer active
//     o_dbg_state          : current sequencer state encoding
// ---------------------------------------------------------------------------
module hd44780_cmd_queue
    import hd44780_cmd_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DLY_SHORT  = `H4_DELAY_53US,
    parameter int DLY_LONG   = `H4_DELAY_1P52MS,
    parameter int TIMER_BITS = `H4_TIMER_BITS
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   i_wr,
    input  logic                   i_rs,
    input  logic [7:0]             i_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_stb,
    output logic                   o_rs,
    output logic [7:0]             o_data,
    input  logic                   i_bs_busy,
    output logic                   o_busy,
    output logic [2:0]             o_dbg_state
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_POP   = 3'd1;
    localparam logic [2:0] ST_STB   = 3'd2;
    localparam logic [2:0] ST_WBUSY = 3'd3;
    localparam logic [2:0] ST_WDONE = 3'd4;
    localparam logic [2:0] ST_DELAY = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        POP   = ST_POP,
        STB   = ST_STB,
        WBUSY = ST_WBUSY,
        WDONE = ST_WDONE,
        DELAY = ST_DELAY
    } state_t;

    localparam int WB_BITS = $clog2(WBUSY_TIMEOUT);

    state_t                 state;
    logic [TIMER_BITS-1:0]  dly_cnt;
    logic [WB_BITS-1:0]     wb_cnt;
    h4_entry_t              head;
    h4_entry_t              push_entry;
    logic                   pop;

    assign push_entry = '{rs: i_rs, data: i_data};
    assign pop        = (state == POP);

    hd44780_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLK_I),
        .rst_n      (RST_I),
        .push       (i_wr),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (o_full),
        .empty      (o_empty),
        .count      (o_count)
    );

    assign o_busy      = !o_empty || (state != IDLE);
    assign o_dbg_state = state;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state   <= IDLE;
            dly_cnt <= '0;
            wb_cnt  <= '0;
            o_stb   <= 1'b0;
            o_rs    <= 1'b0;
            o_data  <= '0;
        end else begin
            // o_stb is registered. It is high only during the cycle spent in STB.
            o_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (!o_empty && !i_bs_busy) begin
                        state <= POP;
                    end
                end
                POP: begin
                    o_rs   <= head.rs;
                    o_data <= head.data;
                    o_stb  <= 1'b1;
                    state  <= STB;
                end
                STB: begin
                    wb_cnt <= '0;
                    state  <= WBUSY;
                end
                WBUSY: begin
                    // Leave on the sender's busy flag, or after the timeout
                    // if the handshake never arrives.
                    if (i_bs_busy || (wb_cnt == WB_BITS'(WBUSY_TIMEOUT - 1))) begin
                        state <= WDONE;
                    end else begin
                        wb_cnt <= wb_cnt + WB_BITS'(1);
                    end
                end
                WDONE: begin
                    if (!i_bs_busy) begin
                        dly_cnt <= is_long_cmd('{rs: o_rs, data: o_data})
                                   ? TIMER_BITS'(DLY_LONG) : TIMER_BITS'(DLY_SHORT);
                        state   <= DELAY;
                    end
                end
                DELAY: begin
                    if (dly_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        dly_cnt <= dly_cnt - TIMER_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hd44780_cmd_queue.md
HD44780_CMD_QUEUE -- requirements
Module: hd44780_cmd_queue

Interface
REQ-001 SHALL have parameters: DEPTH, default 16, FIFO entries (power of 2); DLY_SHORT, default `H4_DELAY_53US, post-byte settle ticks; DLY_LONG, default `H4_DELAY_1P52MS, post clear/home settle ticks; TIMER_BITS, default `H4_TIMER_BITS, delay counter width.
REQ-002 SHALL have the following ports, clock and reset first:
  - CLK_I  in  1  system clock.
  - RST_I  in  1  reset, asynchronous, active-low.
  - i_wr  in  1  push request.
  - i_rs  in  1  RS of byte to push (0 = command, 1 = data).
  - i_data  in  8  byte to push.
  - o_full  out  1  FIFO full.
  - o_empty  out  1  FIFO empty.
  - o_count  out  log2(DEPTH)+1  occupancy.
  - o_stb  out  1  strobe to byte sender.
  - o_rs  out  1  RS to byte sender.
  - o_data  out  8  byte to byte sender.
  - i_bs_busy  in  1  byte sender busy.
  - o_busy  out  1  queue non-empty or sequencer not IDLE.

Function
REQ-003 SHALL store {rs, data} entries in a DEPTH-entry circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-004 SHALL accept a push on any rising edge where i_wr=1 and o_full=0; a push while full SHALL be dropped silently with no state change.
REQ-005 SHALL, on a simultaneous push and pop with the FIFO non-empty, keep o_count unchanged; a push to an empty FIFO SHALL become poppable the next cycle.
REQ-006 SHALL implement a sequencer with states IDLE, POP, STB, WBUSY, WDONE, DELAY.
REQ-007 SHALL step IDLE -> POP when o_empty=0 and i_bs_busy=0; POP SHALL register the head entry into o_rs/o_data and advance the read pointer.
REQ-008 SHALL assert o_stb in STB for exactly one cycle, with o_rs and o_data stable from POP through WDONE.
REQ-009 SHALL, in WBUSY, wait for i_bs_busy=1, then go to WDONE; WBUSY SHALL fall through to WDONE after 4 cycles without busy (lost-handshake guard).
REQ-010 SHALL, in WDONE, wait for i_bs_busy=0, then load the delay counter and go to DELAY.
REQ-011 SHALL load the delay counter with DLY_LONG when rs=0 and data[7:1]=7'b0000000 or data[7:1]=7'b0000001 (clear 0x01, home 0x02/0x03), and with DLY_SHORT otherwise.
REQ-012 SHALL count the delay down to 0 in DELAY, then return to IDLE; back-to-back entries SHALL therefore be separated by at least the delay plus 3 cycles.
REQ-013 SHALL drive o_busy combinationally as (o_empty=0) or (state != IDLE).
REQ-014 SHALL keep o_stb low in every state except STB.

Reset
REQ-015 SHALL, on RST_I low, asynchronously clear both pointers and the delay counter, and set state to IDLE, o_stb=0, o_rs=0, o_data=0, o_count=0, o_empty=1, o_full=0.
REQ-016 SHALL, on reset mid-sequence, discard all queued entries and any in-flight byte without emitting a further strobe.
REQ-017 SHALL release reset with no action before the first rising CLK_I edge after RST_I goes high.

Structure
REQ-018 SHALL take DLY_* and TIMER_BITS defaults from the shared hd44780 build/sim config include, adding `H4_DELAY_1P52MS there.
REQ-019 SHALL place the state encodings as localparams within the module.
REQ-020 SHALL use one sub-module, hd44780_cmd_fifo (storage, pointers, count, flags); the sequencer stays in hd44780_cmd_queue.

Verification
REQ-021 Bench with DEPTH=4, DLY_SHORT=4, DLY_LONG=20, and a byte sender model that raises busy 1 cycle after o_stb and holds it 10 cycles:
  - Push (1, 0x41) -> one o_stb pulse with o_rs=1, o_data=0x41; next o_stb no earlier than 4+3 cycles after busy falls.
  - Push (0, 0x01), then (1, 0x42) -> gap after busy falls ≥ 20 cycles before the 0x42 strobe.
  - Push 5 entries with the sequencer stalled by busy held high -> o_full=1 after 4 pushes, 5th dropped, exactly 4 bytes emitted in order.
  - Simultaneous push and pop at count=2 -> o_count stays 2; pointer wrap over 10 entries preserves order.
  - Busy never asserted -> WBUSY exits after 4 cycles and the queue drains.
  - RST_I low during DELAY with 3 entries queued -> o_empty=1 and o_stb=0 immediately, no strobes after release.
